pll_reconfig_ctrl: RTL and testbench
====================================

# pll_reconfig_ctrl

Sequencer for the rPLL in dynamic-divider mode (DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL = "true"). It drives the PLL's RESET and IDSEL/FBDSEL/ODSEL inputs and watches LOCK. It applies a requested divider set, waits for a stable lock with timeout and retry, and recovers from lock loss. It also holds the downstream system reset until the PLL output is trustworthy. It runs on the PLL's input reference clock, never on a PLL output.

## Interface
- RST_CYCLES, 16: cycles pll_reset is held high per attempt (≥2).
- SETTLE_CYCLES, 1024: cycles synced lock must stay high before the output is declared stable.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK per attempt.
- MAX_RETRY, 3: extra attempts after the first timeout before ERROR.
- DEF_IDSEL / DEF_FBDSEL / DEF_ODSEL, 6'd0 each: raw select codes applied after reset.
- clkin  in  1  reference clock (PLL CLKIN net).
- rstn  in  1  asynchronous, active-low reset.
- req  in  1  reconfiguration request; accepted only when ready=1.
- cfg_idsel / cfg_fbdsel / cfg_odsel  in  6 each  raw select codes, sampled on acceptance.
- ready  out  1  high in RUN or ERROR.
- pll_lock  in  1  rPLL LOCK, asynchronous to clkin.
- pll_reset  out  1  to rPLL RESET.
- pll_idsel / pll_fbdsel / pll_odsel  out  6 each  to rPLL IDSEL/FBDSEL/ODSEL.
- sys_rst_n  out  1  downstream reset; high only in RUN.
- done  out  1  one-cycle pulse on entry to RUN.
- err  out  1  high while in ERROR.
- relock_cnt  out  8  count of unsolicited lock losses.

## Operation
- pll_lock passes through a 2-FF synchroniser. The result, lock_s, is the only lock signal used.
- All outputs are registered.
- Reset values:
  - pll_reset=1; selects=DEF_*; sys_rst_n=0; done=0; err=0; ready=0; relock_cnt=0.
  - State=RST_ASSERT; retry counter=0.
- RST_ASSERT: pll_reset=1 for RST_CYCLES cycles, then go to WAIT_LOCK with pll_reset=0.
- WAIT_LOCK: the timer counts up.
  - lock_s=1 → SETTLE, timer cleared.
  - Timer reaches LOCK_TIMEOUT-1 with retries < MAX_RETRY → retries+1, go to RST_ASSERT.
  - Timer reaches LOCK_TIMEOUT-1 otherwise → ERROR.
- SETTLE: the counter counts while lock_s=1.
  - lock_s=0 → back to WAIT_LOCK, timer cleared. The WAIT_LOCK timeout budget restarts, and the retry count is unchanged.
  - SETTLE_CYCLES consecutive high cycles → RUN with done pulse, sys_rst_n=1, retries cleared.
- RUN:
  - lock_s falls → sys_rst_n=0 on the same edge that leaves RUN. relock_cnt increments, saturating at 255. State → RST_ASSERT with selects unchanged.
  - req=1 → capture cfg_* into pll_*sel, sys_rst_n=0, go to RST_ASSERT, retries=0.
  - If req and lock loss occur in the same cycle, req wins and relock_cnt does not increment.
- ERROR: pll_reset=0, sys_rst_n=0, err=1.
  - Only req leaves ERROR: cfg is captured and the state goes to RST_ASSERT.
  - lock_s is ignored in ERROR.
- req while ready=0 is ignored, not queued.
- pll_*sel change only on req acceptance or reset. They are stable whenever pll_reset=0.
- Asserting rstn mid-sequence aborts immediately to the reset values. Selects return to DEF_*.

## Timing
- Request accepted at edge N:
  - pll_*sel and pll_reset=1 are valid after N.
  - ready and sys_rst_n are low after N.
- pll_reset falls RST_CYCLES edges after it rose.
- lock_s lags pll_lock by 2 edges.
- From the first synced high: done pulses SETTLE_CYCLES edges later, on the same edge sys_rst_n rises.
- Lock drop → sys_rst_n low 3 edges after pll_lock falls (2 sync + 1 register).
- rstn assertion is asynchronous. Deassertion is taken on the next clkin edge; external sync is the integrator's job.

## Configuration
- PLL_CTRL_RELOCK_CNT_EN defined: relock_cnt is implemented as described.
- Not defined: relock_cnt is tied to 8'd0, the counter is not synthesised, and all other behaviour is identical.

## Test plan
- Power-up: rstn low 5 cycles, model locks 100 cycles after pll_reset falls → pll_reset high exactly 16 cycles; done and sys_rst_n rise 1024+2 cycles after lock; selects=0.
- Reconfig: in RUN, req with cfg=(1,4,4) → pll_*sel=(1,4,4) next edge, sys_rst_n=0, ready=0; full sequence repeats; done pulses once.
- Lock glitch: lock drops for 1 cycle mid-SETTLE → return to WAIT_LOCK, settle counter restarts, done delayed by the full 1024.
- Timeout: model never locks → 4 reset pulses (1+MAX_RETRY), then err=1, ready=1, sys_rst_n=0. A subsequent req with a locking model → RUN, err=0.
- Lock loss in RUN: drop pll_lock → sys_rst_n=0 3 cycles later, relock_cnt=1, relock completes. Run 300 losses → relock_cnt=255 (0 with macro undefined).
- Same-cycle req and lock loss in RUN → new cfg applied, relock_cnt unchanged. rstn pulsed mid-WAIT_LOCK → outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - rPLL dynamic-divider sequencer: reset, lock wait with retry, settle, relock.
// Optional unsolicited-relock counter: define PLL_CTRL_RELOCK_CNT_EN.
module pll_reconfig_ctrl #(
    parameter int         RST_CYCLES    = 16,
    parameter int         SETTLE_CYCLES = 1024,
    parameter int         LOCK_TIMEOUT  = 65536,
    parameter int         MAX_RETRY     = 3,
    parameter logic [5:0] DEF_IDSEL     = 6'd0,
    parameter logic [5:0] DEF_FBDSEL    = 6'd0,
    parameter logic [5:0] DEF_ODSEL     = 6'd0
) (
    input  logic       clkin,
    input  logic       rstn,
    input  logic       req,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       ready,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       sys_rst_n,
    output logic       done,
    output logic       err,
    output logic [7:0] relock_cnt
);

    localparam logic [2:0] ST_RST_ASSERT = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] ST_SETTLE     = 3'd2;
    localparam logic [2:0] ST_RUN        = 3'd3;
    localparam logic [2:0] ST_ERROR      = 3'd4;

    logic [2:0]  state;
    logic [31:0] timer;
    logic [31:0] retries;
    logic        lock_meta;
    logic        lock_s;
    logic        accept;

    // LOCK is asynchronous to clkin
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    assign accept = req && ((state == ST_RUN) || (state == ST_ERROR));

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_RST_ASSERT;
            timer      <= 32'd0;
            retries    <= 32'd0;
            pll_reset  <= 1'b1;
            pll_idsel  <= DEF_IDSEL;
            pll_fbdsel <= DEF_FBDSEL;
            pll_odsel  <= DEF_ODSEL;
            sys_rst_n  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ready      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // a request beats a simultaneous lock loss
                state      <= ST_RST_ASSERT;
                timer      <= 32'd0;
                retries    <= 32'd0;
                pll_reset  <= 1'b1;
                pll_idsel  <= cfg_idsel;
                pll_fbdsel <= cfg_fbdsel;
                pll_odsel  <= cfg_odsel;
                sys_rst_n  <= 1'b0;
                err        <= 1'b0;
                ready      <= 1'b0;
            end else begin
                case (state)
                    ST_RST_ASSERT: begin
                        if (timer == 32'(RST_CYCLES - 1)) begin
                            state     <= ST_WAIT_LOCK;
                            timer     <= 32'd0;
                            pll_reset <= 1'b0;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= ST_SETTLE;
                            timer <= 32'd0;
                        end else if (timer == 32'(LOCK_TIMEOUT - 1)) begin
                            timer <= 32'd0;
                            if (retries < 32'(MAX_RETRY)) begin
                                retries   <= retries + 32'd1;
                                state     <= ST_RST_ASSERT;
                                pll_reset <= 1'b1;
                            end else begin
                                state <= ST_ERROR;
                                err   <= 1'b1;
                                ready <= 1'b1;
                            end
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                    ST_SETTLE: begin
                        // the WAIT_LOCK cycle that saw lock_s counts as the first stable cycle
                        if (!lock_s) begin
                            state <= ST_WAIT_LOCK;
                            timer <= 32'd0;
                        end else if (timer == 32'(SETTLE_CYCLES - 2)) begin
                            state     <= ST_RUN;
                            timer     <= 32'd0;
                            retries   <= 32'd0;
                            done      <= 1'b1;
                            sys_rst_n <= 1'b1;
                            ready     <= 1'b1;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                    ST_RUN: begin
                        if (!lock_s) begin
                            state     <= ST_RST_ASSERT;
                            timer     <= 32'd0;
                            pll_reset <= 1'b1;
                            sys_rst_n <= 1'b0;
                            ready     <= 1'b0;
                        end
                    end
                    ST_ERROR: begin
                        pll_reset <= 1'b0;
                        sys_rst_n <= 1'b0;
                        err       <= 1'b1;
                    end
                    default: begin
                        state     <= ST_RST_ASSERT;
                        timer     <= 32'd0;
                        pll_reset <= 1'b1;
                        sys_rst_n <= 1'b0;
                        ready     <= 1'b0;
                        err       <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PLL_CTRL_RELOCK_CNT_EN
    logic lock_lost;
    assign lock_lost = (state == ST_RUN) && !req && !lock_s;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            relock_cnt <= 8'd0;
        end else if (lock_lost && (relock_cnt != 8'hff)) begin
            relock_cnt <= relock_cnt + 8'd1;
        end
    end
`else
    assign relock_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - self-checking bench for pll_reconfig_ctrl with a behavioural rPLL lock model.
module tb_pll_reconfig_ctrl;

    localparam int RST = 16;
    localparam int SET = 32;
    localparam int LT  = 200;
    localparam int MR  = 3;
    localparam int W_RUN     = 0;
    localparam int W_RST_LOW = 1;

    logic       clkin;
    logic       rstn;
    logic       req;
    logic [5:0] cfg_idsel;
    logic [5:0] cfg_fbdsel;
    logic [5:0] cfg_odsel;
    logic       ready;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       sys_rst_n;
    logic       done;
    logic       err;
    logic [7:0] relock_cnt;

    int asserts = 0;
    int fails = 0;
    int cyc = 0;
    int lock_delay = 100;
    bit model_locks = 1'b1;
    bit force_low = 1'b0;
    int lock_rise_cyc = 0;
    int lock_fall_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rst_rise_cnt = 0;
    int rst_fall_cyc = 0;
    int exp_relock = 0;

    pll_reconfig_ctrl #(
        .RST_CYCLES(RST), .SETTLE_CYCLES(SET), .LOCK_TIMEOUT(LT), .MAX_RETRY(MR),
        .DEF_IDSEL(6'd0), .DEF_FBDSEL(6'd0), .DEF_ODSEL(6'd0)
    ) dut (
        .clkin(clkin), .rstn(rstn), .req(req),
        .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
        .ready(ready), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .sys_rst_n(sys_rst_n), .done(done), .err(err), .relock_cnt(relock_cnt)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    initial begin
        forever begin
            @(posedge clkin);
            cyc++;
        end
    end

    // rPLL: locks lock_delay cycles after RESET falls; force_low models a lock drop
    initial begin : pll_model
        int  mcnt;
        logic nxt;
        mcnt = 0;
        pll_lock = 1'b0;
        forever begin
            @(negedge clkin);
            if (pll_reset || !model_locks) mcnt = 0;
            else if (mcnt < lock_delay) mcnt++;
            nxt = model_locks && !pll_reset && (mcnt >= lock_delay) && !force_low;
            if (nxt && !pll_lock) lock_rise_cyc = cyc;
            if (!nxt && pll_lock) lock_fall_cyc = cyc;
            pll_lock = nxt;
        end
    end

    initial begin : monitor
        logic        prev_rst;
        logic [17:0] prev_sel;
        prev_rst = 1'b1;
        prev_sel = 18'd0;
        forever begin
            @(negedge clkin);
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (pll_reset && !prev_rst) rst_rise_cnt++;
            if (!pll_reset && prev_rst) rst_fall_cyc = cyc;
            asserts++;
            if (!pll_reset && !prev_rst && ({pll_idsel, pll_fbdsel, pll_odsel} !== prev_sel)) begin
                fails++;
                $display("FAIL sel_stable: got %h required %h", {pll_idsel, pll_fbdsel, pll_odsel}, prev_sel);
            end
            asserts++;
            if (sys_rst_n && (!ready || err || pll_reset)) begin
                fails++;
                $display("FAIL run_outputs: ready=%b err=%b pll_reset=%b while sys_rst_n=1", ready, err, pll_reset);
            end
            asserts++;
            if (done && !sys_rst_n) begin
                fails++;
                $display("FAIL done_with_sys_rst: sys_rst_n=%b required 1", sys_rst_n);
            end
            prev_rst = pll_reset;
            prev_sel = {pll_idsel, pll_fbdsel, pll_odsel};
        end
    end

    task automatic step();
        @(negedge clkin);
        #1;
    endtask

    task automatic wait_for(input int what, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if ((what == W_RUN && sys_rst_n === 1'b1) || (what == W_RST_LOW && pll_reset === 1'b0)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int relock_next(input int v);
`ifdef PLL_CTRL_RELOCK_CNT_EN
        return (v < 255) ? v + 1 : 255;
`else
        return v;
`endif
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        req = 1'b0;
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = 18'd0;
        repeat (5) step();
        asserts++;
        if (pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || done !== 1'b0 || err !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: pll_reset=%b sys_rst_n=%b done=%b err=%b ready=%b required 1 0 0 0 0",
                     pll_reset, sys_rst_n, done, err, ready);
        end
        asserts++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== 18'd0 || relock_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_values: sel=%h relock=%0d required 0 0", {pll_idsel, pll_fbdsel, pll_odsel}, relock_cnt);
        end
    endtask

    task automatic test_power_up();
        int c0;
        bit ok;
        lock_delay = 100;
        model_locks = 1'b1;
        c0 = cyc;
        rstn = 1'b1;
        wait_for(W_RST_LOW, 100, ok);
        asserts++;
        if (!ok || rst_fall_cyc - c0 != RST) begin
            fails++;
            $display("FAIL pwr_reset_len: got %0d required %0d (ok=%0d)", rst_fall_cyc - c0, RST, ok);
        end
        wait_for(W_RUN, 1000, ok);
        asserts++;
        if (!ok || done_cyc - lock_rise_cyc != SET + 2) begin
            fails++;
            $display("FAIL pwr_done_latency: got %0d required %0d (ok=%0d)", done_cyc - lock_rise_cyc, SET + 2, ok);
        end
        asserts++;
        if (done_cnt != 1 || ready !== 1'b1 || {pll_idsel, pll_fbdsel, pll_odsel} !== 18'd0) begin
            fails++;
            $display("FAIL pwr_run: done_cnt=%0d ready=%b sel=%h required 1 1 0", done_cnt, ready,
                     {pll_idsel, pll_fbdsel, pll_odsel});
        end
    endtask

    task automatic test_reconfig();
        for (int i = 0; i < 3; i++) begin
            logic [17:0] cfg;
            int a;
            int d0;
            bit ok;
            cfg = (i == 0) ? {6'd1, 6'd4, 6'd4} : 18'($urandom);
            lock_delay = $urandom_range(4, 60);
            d0 = done_cnt;
            {cfg_idsel, cfg_fbdsel, cfg_odsel} = cfg;
            req = 1'b1;
            step();
            req = 1'b0;
            a = cyc;
            asserts++;
            if ({pll_idsel, pll_fbdsel, pll_odsel} !== cfg || pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0) begin
                fails++;
                $display("FAIL reconfig_accept: sel=%h rst=%b sys=%b ready=%b required %h 1 0 0",
                         {pll_idsel, pll_fbdsel, pll_odsel}, pll_reset, sys_rst_n, ready, cfg);
            end
            wait_for(W_RST_LOW, 100, ok);
            asserts++;
            if (!ok || rst_fall_cyc - a != RST) begin
                fails++;
                $display("FAIL reconfig_reset_len: got %0d required %0d", rst_fall_cyc - a, RST);
            end
            {cfg_idsel, cfg_fbdsel, cfg_odsel} = ~cfg;
            req = 1'b1;
            step();
            req = 1'b0;
            asserts++;
            if ({pll_idsel, pll_fbdsel, pll_odsel} !== cfg || pll_reset !== 1'b0) begin
                fails++;
                $display("FAIL req_ignored: sel=%h rst=%b required %h 0", {pll_idsel, pll_fbdsel, pll_odsel}, pll_reset, cfg);
            end
            wait_for(W_RUN, 1000, ok);
            asserts++;
            if (!ok || done_cnt - d0 != 1 || done_cyc - lock_rise_cyc != SET + 2) begin
                fails++;
                $display("FAIL reconfig_done: pulses=%0d latency=%0d required 1 %0d", done_cnt - d0,
                         done_cyc - lock_rise_cyc, SET + 2);
            end
        end
    endtask

    task automatic test_lock_glitch();
        logic [17:0] cfg;
        int r1;
        int k;
        int d0;
        bit ok;
        lock_delay = $urandom_range(4, 30);
        cfg = 18'($urandom);
        r1 = lock_rise_cyc;
        d0 = done_cnt;
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = cfg;
        req = 1'b1;
        step();
        req = 1'b0;
        for (int n = 0; n < 200 && lock_rise_cyc == r1; n++) step();
        asserts++;
        if (lock_rise_cyc == r1) begin
            fails++;
            $display("FAIL glitch_lock: no lock rise seen, got %0d required a new value", lock_rise_cyc);
        end
        r1 = lock_rise_cyc;
        k = $urandom_range(2, SET - 4);
        while (cyc < r1 + k) step();
        force_low = 1'b1;
        step();
        force_low = 1'b0;
        wait_for(W_RUN, 1000, ok);
        asserts++;
        if (!ok || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL glitch_pulses: got %0d required 1", done_cnt - d0);
        end
        asserts++;
        if (done_cyc - r1 != k + SET + 4) begin
            fails++;
            $display("FAIL glitch_delay: got %0d required %0d", done_cyc - r1, k + SET + 4);
        end
    endtask

    task automatic test_timeout();
        logic [17:0] cfg;
        int a;
        int p0;
        int d0;
        bit ok;
        model_locks = 1'b0;
        cfg = 18'($urandom);
        p0 = rst_rise_cnt;
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = cfg;
        req = 1'b1;
        step();
        req = 1'b0;
        a = cyc;
        for (int n = 0; n < (1 + MR) * (RST + LT) + 50 && err !== 1'b1; n++) step();
        asserts++;
        if (err !== 1'b1 || cyc - a != (1 + MR) * (RST + LT)) begin
            fails++;
            $display("FAIL timeout_time: err=%b after %0d cycles required 1 after %0d", err, cyc - a, (1 + MR) * (RST + LT));
        end
        asserts++;
        if (rst_rise_cnt - p0 != 1 + MR) begin
            fails++;
            $display("FAIL timeout_pulses: got %0d required %0d", rst_rise_cnt - p0, 1 + MR);
        end
        asserts++;
        if (ready !== 1'b1 || sys_rst_n !== 1'b0 || pll_reset !== 1'b0 || {pll_idsel, pll_fbdsel, pll_odsel} !== cfg) begin
            fails++;
            $display("FAIL error_outputs: ready=%b sys=%b rst=%b sel=%h required 1 0 0 %h", ready, sys_rst_n, pll_reset,
                     {pll_idsel, pll_fbdsel, pll_odsel}, cfg);
        end
        model_locks = 1'b1;
        d0 = done_cnt;
        repeat (lock_delay + 20) step();
        asserts++;
        if (err !== 1'b1 || done_cnt != d0 || sys_rst_n !== 1'b0) begin
            fails++;
            $display("FAIL error_ignores_lock: err=%b pulses=%0d sys=%b required 1 0 0", err, done_cnt - d0, sys_rst_n);
        end
        cfg = 18'($urandom);
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = cfg;
        req = 1'b1;
        step();
        req = 1'b0;
        asserts++;
        if (err !== 1'b0 || ready !== 1'b0 || {pll_idsel, pll_fbdsel, pll_odsel} !== cfg) begin
            fails++;
            $display("FAIL error_exit: err=%b ready=%b sel=%h required 0 0 %h", err, ready, {pll_idsel, pll_fbdsel, pll_odsel}, cfg);
        end
        wait_for(W_RUN, 1000, ok);
        asserts++;
        if (!ok || err !== 1'b0 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL error_recover: ok=%0d err=%b pulses=%0d required 1 0 1", ok, err, done_cnt - d0);
        end
    endtask

    task automatic test_lock_loss();
        logic [17:0] sel0;
        int d;
        bit ok;
        lock_delay = 4;
        sel0 = {pll_idsel, pll_fbdsel, pll_odsel};
        force_low = 1'b1;
        step();
        d = lock_fall_cyc;
        while (cyc < d + 2) step();
        asserts++;
        if (sys_rst_n !== 1'b1) begin
            fails++;
            $display("FAIL loss_early: sys_rst_n=%b required 1 two edges after drop", sys_rst_n);
        end
        step();
        force_low = 1'b0;
        exp_relock = relock_next(exp_relock);
        asserts++;
        if (sys_rst_n !== 1'b0 || ready !== 1'b0 || pll_reset !== 1'b1) begin
            fails++;
            $display("FAIL loss_edge: sys=%b ready=%b rst=%b required 0 0 1", sys_rst_n, ready, pll_reset);
        end
        asserts++;
        if (relock_cnt !== 8'(exp_relock)) begin
            fails++;
            $display("FAIL relock_first: got %0d required %0d", relock_cnt, exp_relock);
        end
        wait_for(W_RUN, 500, ok);
        asserts++;
        if (!ok || {pll_idsel, pll_fbdsel, pll_odsel} !== sel0) begin
            fails++;
            $display("FAIL relock_run: ok=%0d sel=%h required 1 %h", ok, {pll_idsel, pll_fbdsel, pll_odsel}, sel0);
        end
        for (int i = 0; i < 300; i++) begin
            force_low = 1'b1;
            for (int n = 0; n < 20 && pll_reset !== 1'b1; n++) step();
            force_low = 1'b0;
            exp_relock = relock_next(exp_relock);
            wait_for(W_RUN, 500, ok);
            asserts++;
            if (!ok) begin
                fails++;
                $display("FAIL relock_loop: iteration %0d did not return to run, required run", i);
                break;
            end
        end
        asserts++;
        if (relock_cnt !== 8'(exp_relock)) begin
            fails++;
            $display("FAIL relock_saturate: got %0d required %0d", relock_cnt, exp_relock);
        end
    endtask

    task automatic test_req_and_loss();
        logic [17:0] cfg;
        int d;
        bit ok;
        cfg = 18'($urandom);
        force_low = 1'b1;
        step();
        d = lock_fall_cyc;
        while (cyc < d + 2) step();
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = cfg;
        req = 1'b1;
        step();
        req = 1'b0;
        force_low = 1'b0;
        asserts++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== cfg || pll_reset !== 1'b1 || sys_rst_n !== 1'b0) begin
            fails++;
            $display("FAIL same_cycle_cfg: sel=%h rst=%b sys=%b required %h 1 0", {pll_idsel, pll_fbdsel, pll_odsel},
                     pll_reset, sys_rst_n, cfg);
        end
        asserts++;
        if (relock_cnt !== 8'(exp_relock)) begin
            fails++;
            $display("FAIL same_cycle_relock: got %0d required %0d", relock_cnt, exp_relock);
        end
        wait_for(W_RUN, 500, ok);
        asserts++;
        if (!ok || {pll_idsel, pll_fbdsel, pll_odsel} !== cfg) begin
            fails++;
            $display("FAIL same_cycle_run: ok=%0d sel=%h required 1 %h", ok, {pll_idsel, pll_fbdsel, pll_odsel}, cfg);
        end
    endtask

    task automatic test_async_reset();
        logic [17:0] cfg;
        int c0;
        bit ok;
        cfg = 18'($urandom);
        cfg[0] = 1'b1;
        model_locks = 1'b0;
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = cfg;
        req = 1'b1;
        step();
        req = 1'b0;
        wait_for(W_RST_LOW, 100, ok);
        repeat (5) step();
        #2 rstn = 1'b0;
        #1;
        asserts++;
        if (pll_reset !== 1'b1 || {pll_idsel, pll_fbdsel, pll_odsel} !== 18'd0 || sys_rst_n !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_main: rst=%b sel=%h sys=%b required 1 0 0 (wait ok=%0d)", pll_reset,
                     {pll_idsel, pll_fbdsel, pll_odsel}, sys_rst_n, ok);
        end
        exp_relock = 0;
        asserts++;
        if (ready !== 1'b0 || err !== 1'b0 || done !== 1'b0 || relock_cnt !== 8'(exp_relock)) begin
            fails++;
            $display("FAIL async_reset_misc: ready=%b err=%b done=%b relock=%0d required 0 0 0 0", ready, err, done, relock_cnt);
        end
        repeat (3) step();
        model_locks = 1'b1;
        lock_delay = 10;
        c0 = cyc;
        rstn = 1'b1;
        wait_for(W_RST_LOW, 100, ok);
        asserts++;
        if (!ok || rst_fall_cyc - c0 != RST) begin
            fails++;
            $display("FAIL rerun_reset_len: got %0d required %0d", rst_fall_cyc - c0, RST);
        end
        wait_for(W_RUN, 500, ok);
        asserts++;
        if (!ok || done_cyc - lock_rise_cyc != SET + 2 || {pll_idsel, pll_fbdsel, pll_odsel} !== 18'd0) begin
            fails++;
            $display("FAIL rerun_done: latency=%0d sel=%h required %0d 0", done_cyc - lock_rise_cyc,
                     {pll_idsel, pll_fbdsel, pll_odsel}, SET + 2);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_reconfig();
        test_lock_glitch();
        test_timeout();
        test_lock_loss();
        test_req_and_loss();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
